ether_tx: RTL

RMII transmit framer: accepts a frame as a stream of 2-bit dibits on a valid/ready/last interface and drives the PHY `txen`/`txd` pins. It prepends the preamble and SFD, passes payload dibits through, optionally appends the CRC-32 FCS, and enforces the inter-packet gap. It is the transmit-side counterpart of the `ether` RMII receiver and uses the same dibit ordering: the preamble is `2'b10`, the SFD dibit is `2'b11`, and `bit[1]` is the earlier wire bit.

---
 rtl/ether_tx_if.sv | 11 +
 rtl/ether_tx.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/ether_tx_if.sv
// ether_tx_if: dibit stream from the frame source into the RMII transmit framer.
// The master drives valid/data/last and the slave returns ready.
interface ether_tx_if;
   logic       axiiv;
   logic [1:0] axiid;
   logic       axiil;
   logic       axiir;

   modport master (output axiiv, output axiid, output axiil, input axiir);
   modport slave  (input axiiv, input axiid, input axiil, output axiir);
endinterface

// File: rtl/ether_tx.sv
// ether_tx: RMII transmit framer. Emits preamble + SFD, passes payload dibits
// through one register stage, optionally appends the CRC-32 FCS, then holds the
// line idle for the inter-packet gap. Dibit order: txd[1] is the earlier wire bit.
// Optional feature macro: ETHER_TX_FCS_EN (builds the CRC datapath and FCS state).
module ether_tx #(
   parameter int PREAMBLE_DIBITS = 31,
   parameter int IPG_CYCLES      = 48
) (
   input  logic       clk,
   input  logic       rst,
   ether_tx_if.slave  axi,
   output logic       txen,
   output logic [1:0] txd,
   output logic       busy
);

   // One shared counter serves preamble, FCS and gap timing, so size it for the longest.
   localparam int CNT_MAX = (PREAMBLE_DIBITS > IPG_CYCLES) ?
                            ((PREAMBLE_DIBITS > 16) ? PREAMBLE_DIBITS : 16) :
                            ((IPG_CYCLES > 16) ? IPG_CYCLES : 16);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_DIBITS);
   localparam logic [CNT_W-1:0] IPG_LAST = CNT_W'(IPG_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      PREAMBLE = 3'd1,
      DATA     = 3'd2,
      FCS      = 3'd3,
      IPG      = 3'd4
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;

`ifdef ETHER_TX_FCS_EN
   localparam logic [CNT_W-1:0] FCS_LAST = CNT_W'(15);
   localparam logic [31:0]      CRC_POLY = 32'hEDB88320;

   logic [31:0] crc;

   // Reflected CRC-32 advanced by one dibit; d[1] is the earlier bit on the wire.
   function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 1; i >= 0; i--) begin
         r = (r >> 1) ^ (((r[0] ^ d[i]) == 1'b1) ? CRC_POLY : 32'h0);
      end
      return r;
   endfunction
`endif

   // Framer FSM: every output is a register updated together with the state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         txen      <= 1'b0;
         txd       <= 2'b00;
         axi.axiir <= 1'b0;
         busy      <= 1'b0;
`ifdef ETHER_TX_FCS_EN
         crc       <= 32'hFFFFFFFF;
`endif
      end else begin
         case (state)
            IDLE: begin
               // The pending dibit stays on axiid; only its presence starts a frame.
               if (axi.axiiv) begin
                  state <= PREAMBLE;
                  cnt   <= CNT_W'(1);
                  txen  <= 1'b1;
                  txd   <= 2'b10;
                  busy  <= 1'b1;
`ifdef ETHER_TX_FCS_EN
                  crc   <= 32'hFFFFFFFF;
`endif
               end
            end

            PREAMBLE: begin
               if (cnt == PRE_LAST) begin
                  txd       <= 2'b11;
                  cnt       <= '0;
                  state     <= DATA;
                  axi.axiir <= 1'b1;
               end else begin
                  txd <= 2'b10;
                  cnt <= cnt + CNT_W'(1);
               end
            end

            DATA: begin
               if (axi.axiiv) begin
                  txd  <= axi.axiid;
                  txen <= 1'b1;
`ifdef ETHER_TX_FCS_EN
                  crc  <= crc_dibit(crc, axi.axiid);
`endif
                  if (axi.axiil) begin
                     axi.axiir <= 1'b0;
                     cnt       <= '0;
`ifdef ETHER_TX_FCS_EN
                     state     <= FCS;
`else
                     state     <= IPG;
`endif
                  end
               end else begin
                  // Underrun: cut the frame short; the receiver sees a truncated frame.
                  txen      <= 1'b0;
                  txd       <= 2'b00;
                  axi.axiir <= 1'b0;
                  cnt       <= '0;
                  state     <= IPG;
               end
            end

`ifdef ETHER_TX_FCS_EN
            FCS: begin
               // ~CRC goes out LSB first; shift the register down two bits per dibit.
               txd <= {~crc[0], ~crc[1]};
               crc <= {2'b11, crc[31:2]};
               if (cnt == FCS_LAST) begin
                  cnt   <= '0;
                  state <= IPG;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
`endif

            IPG: begin
               txen <= 1'b0;
               txd  <= 2'b00;
               if (cnt == IPG_LAST) begin
                  cnt   <= '0;
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            default: begin
               state     <= IDLE;
               cnt       <= '0;
               txen      <= 1'b0;
               txd       <= 2'b00;
               axi.axiir <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule
